// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encoding, the instruction word loaded by flushes, and the register-match
// helper used by the load-use comparator.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // addi x0, x0, 0 -- what a flushed IF/ID or ID/EX register holds
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // x0 is hard-wired to zero, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an instruction in ID that reads the
// destination of a load currently in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       load_use
);

    // Pure combinational match; priority against branches is resolved in the top
    always_comb begin
        load_use = ex_mem_read & (reg_match(ex_rd, rs1) | reg_match(ex_rd, rs2));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Priority of pipeline controls: halt/reset > memory stall > branch > load-use.
//
// Data-memory handshake: dmem_req is held high for as long as a load/store
// sits in MEM (and the FSM is not halted); the access completes in the cycle
// dmem_req and dmem_ready are both high. Until then the whole pipeline is
// frozen and MEM/WB receives a bubble.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RD,
    input  logic             EX_Branch_taken,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             EX_MEM_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_bubble,
    output logic             dmem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    // wait_cnt value during the last MEM_WAIT cycle allowed before timeout
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic               load_use;
    logic               mem_op;
    logic               active;
    logic               mem_stall;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ID_EX_MemRead),
        .ex_rd       (ID_EX_RD),
        .rs1         (IF_ID_RS1),
        .rs2         (IF_ID_RS2),
        .load_use    (load_use)
    );

    // Next-state logic and the priority mux for all pipeline controls
    always_comb begin
        mem_op     = EX_MEM_MemRead | EX_MEM_MemWrite;
        active     = (state_q != HALT);
        mem_stall  = active & mem_op & ~dmem_ready;

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        PC_en         = 1'b1;
        IF_ID_en      = 1'b1;
        ID_EX_en      = 1'b1;
        EX_MEM_en     = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        MEM_WB_bubble = 1'b0;
        dmem_req      = active & mem_op;

        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // access done (or withdrawn); a pending halt is taken from RUN
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            HALT: begin
                if (!halt_req && !timeout_q) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!active || mem_stall) begin
            PC_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (EX_Branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
        end

        // Reset freezes the pipeline and abandons any memory access at once
        if (!rstn) begin
            PC_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            IF_ID_flush   = 1'b0;
            ID_EX_flush   = 1'b0;
            MEM_WB_bubble = 1'b1;
            dmem_req      = 1'b0;
        end
    end

    // State, wait counter, sticky timeout and saturating stall counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (!PC_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign state       = state_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences multi-cycle data-memory accesses through a req/ready handshake and provides a debug halt. The block owns load-use, branch-flush and memory-wait hazards, plus a saturating stall-cycle counter.

## Interface
- MEM_TIMEOUT, 15: max MEM_WAIT cycles before timeout (≥1)
- CNT_W, 32: stall counter width
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- IF_ID_RS1, IF_ID_RS2  in  5  source registers of instruction in ID
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RD  in  5  destination of instruction in EX
- EX_Branch_taken  in  1  branch/jump in EX redirects PC
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1  memory op in MEM stage
- dmem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  debug halt request (level)
- PC_en, IF_ID_en, ID_EX_en, EX_MEM_en  out  1  register load enables
- IF_ID_flush, ID_EX_flush  out  1  load NOP into register
- MEM_WB_bubble  out  1  MEM/WB loads RegWrite=0, MemtoReg=0
- dmem_req  out  1  data memory request
- mem_timeout  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  cycles with PC_en=0
- state  out  2  FSM state

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset → RUN.
- mem_op = EX_MEM_MemRead | EX_MEM_MemWrite. dmem_req = mem_op in RUN and MEM_WAIT, 0 in HALT.
- Memory stall (highest priority): the stall applies when state is RUN or MEM_WAIT, mem_op is 1 and dmem_ready is 0.
  - During the stall, all four enables are 0, both flushes are 0 and MEM_WB_bubble is 1.
  - RUN → MEM_WAIT on the first such cycle.
- MEM_WAIT:
  - On dmem_ready=1, go to RUN. In that cycle all enables are 1 and the bubble is 0, subject to the branch and load-use rules.
  - wait_cnt counts cycles in MEM_WAIT. When wait_cnt reaches MEM_TIMEOUT with dmem_ready still 0, set mem_timeout and go to HALT.
- Branch (no memory stall): if EX_Branch_taken=1, then IF_ID_flush=1 and ID_EX_flush=1, with all enables 1. Branch overrides load-use.
- Load-use (no memory stall, no branch): the condition is ID_EX_MemRead and ID_EX_RD≠0 and ID_EX_RD equals RS1 or RS2.
  - Response: PC_en=0, IF_ID_en=0, ID_EX_flush=1, EX_MEM_en=1, MEM_WB_bubble=0.
- Otherwise all enables are 1, flushes are 0 and the bubble is 0.
- HALT entry and exit:
  - Entered from RUN when halt_req=1 and no memory stall is active that cycle. A halt_req raised during MEM_WAIT is deferred until the access completes.
  - In HALT all enables are 0, flushes are 0, bubble is 1 and dmem_req is 0.
  - Exit to RUN when halt_req=0 and mem_timeout=0. Only reset clears mem_timeout.
- stall_cnt increments every cycle with rstn=1 and PC_en=0, and saturates at all-ones.

## Timing
- Enable, flush, bubble and dmem_req outputs are combinational from state and inputs. state, wait_cnt, mem_timeout and stall_cnt are registered.
- Zero-wait memory (dmem_ready=1 in the request cycle) causes no stall. An N-cycle access causes N stall cycles.
- Load-use causes exactly 1 stall cycle. A branch flushes 2 instructions.
- Branch held during a memory stall: the flush is asserted in the release cycle.
- While rstn=0, outputs are forced as follows:
  - Enables 0, flushes 0, MEM_WB_bubble 1, dmem_req 0.
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0.
- Reset mid-access abandons the access: the request is not held and the FSM restarts in RUN.

## Structure
- pipe_ctrl_pkg holds the state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2) and the NOP instruction constant used by the flush targets.
- The load-use comparator is a combinational sub-module, hazard_detect. The FSM, counters and priority mux live in pipeline_ctrl.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_RD=5, RS1=5 → one cycle with PC_en=0, IF_ID_en=0, ID_EX_flush=1. Repeating with RD=0 → no stall.
- Branch over load-use: EX_Branch_taken=1 with the load-use condition true → IF_ID_flush=1, ID_EX_flush=1, PC_en=1.
- 3-cycle load: EX_MEM_MemRead=1, dmem_ready low for 3 cycles → 3 cycles with all enables 0 and bubble 1, state=MEM_WAIT. Release cycle: all enables 1; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → mem_timeout=1 and state=HALT after the 4th MEM_WAIT cycle. Dropping halt_req does not exit HALT; rstn pulse → RUN and mem_timeout=0.
- Halt deferral: halt_req raised mid-MEM_WAIT → HALT entered only after the dmem_ready cycle. halt_req=0 → RUN on the next cycle.
- Async reset during MEM_WAIT → dmem_req=0 and state=RUN immediately, without waiting for a clock edge.
